fc_act_writer: RTL

Downstream stage of the fully-connected engine. It consumes the serial `psum`/`valid`/`last` output-node stream and applies optional ReLU. It then writes each result into the next layer's ifmap buffer through that buffer's write port (`wren`/`wrptr`/`wdata`), using the same reversed ordering the FC ifmap loader expects: node k goes to address N-1-k. A 4-entry FIFO absorbs stalls while the destination buffer is busy. A done pulse tells the layer sequencer that the next FC layer can start.

---
 rtl/fc_pkg.sv | 20 ++
 rtl/fc_act_fifo.sv | 59 +++++
 rtl/fc_act_writer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types for the FC activation writer: layer FSM states and the stall-FIFO entry.
package fc_pkg;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 7;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fc_state_e;

    typedef struct packed {
        logic        [ADDR_W-1:0] addr;
        logic signed [DATA_W-1:0] data;
    } fc_wr_t;

endpackage

// File: rtl/fc_act_fifo.sv
// Small synchronous FIFO of pending ifmap writes; push while full is ignored unless a pop
// happens in the same cycle. Head entry is visible combinationally on pop_dat_o.
module fc_act_fifo
    import fc_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fc_wr_t                   push_dat_i,
    input  logic                     pop_i,
    output fc_wr_t                   pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    fc_wr_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     cnt_q;
    logic            wr_en;
    logic            rd_en;

    assign full_o    = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign count_o   = cnt_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            cnt_q <= cnt_q + (PW+1)'(wr_en) - (PW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/fc_act_writer.sv
// Writes FC output nodes (optional ReLU) into the next layer's ifmap buffer at address N-1-k,
// queueing through a small FIFO while the buffer is busy; pulses done after the final write.
module fc_act_writer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic        [ADDR_W-1:0] out_node_num_i,
    input  logic                     relu_en_i,
    input  logic signed [DATA_W-1:0] psum_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    input  logic                     dst_busy_i,
    output logic                     ifmap_wren_o,
    output logic        [ADDR_W-1:0] ifmap_wrptr_o,
    output logic signed [DATA_W-1:0] ifmap_wdata_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    import fc_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fc_state_e               state_q, state_d;
    logic       [ADDR_W-1:0] n_q, n_d;
    logic       [ADDR_W-1:0] k_q, k_d;
    logic                    relu_q, relu_d;
    logic                    err_q, err_d;
    logic                    busy_q, done_q, wren_q;
    logic       [ADDR_W-1:0] wrptr_q;
    logic signed [DATA_W-1:0] wdata_q;

    fc_wr_t                  beat;
    fc_wr_t                  fifo_head;
    logic                    fifo_full, fifo_empty;
    logic       [CNT_W-1:0]  fifo_cnt;
    logic                    beat_vld, is_final, bypass, overflow;
    logic                    fifo_push, fifo_pop;

    always_comb begin
        beat_vld  = valid_i && (state_q == RUN);
        is_final  = (k_q == n_q - ADDR_W'(1));
        beat.addr = n_q - ADDR_W'(1) - k_q;
        beat.data = (relu_q && psum_i[DATA_W-1]) ? '0 : psum_i;
        // Queued entries always drain before a new beat may take the output register.
        fifo_pop  = !fifo_empty && !dst_busy_i;
        bypass    = beat_vld && fifo_empty && !dst_busy_i;
        overflow  = beat_vld && !bypass && fifo_full && !fifo_pop;
        fifo_push = beat_vld && !bypass && !overflow;
    end

    fc_act_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (beat),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        relu_d  = relu_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    err_d = 1'b1;
                end
                if (start_i) begin
                    if (out_node_num_i != '0) begin
                        state_d = RUN;
                        n_d     = out_node_num_i;
                        relu_d  = relu_en_i;
                        k_d     = '0;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (start_i || overflow) begin
                    err_d = 1'b1;
                end
                if (beat_vld) begin
                    k_d = k_q + ADDR_W'(1);
                    // Early last and a missing last on node N-1 both end the layer with an error.
                    if (last_i ^ is_final) begin
                        err_d = 1'b1;
                    end
                    if (last_i || is_final) begin
                        state_d = bypass ? DONE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (start_i || valid_i) begin
                    err_d = 1'b1;
                end
                if (fifo_empty || (fifo_pop && fifo_cnt == CNT_W'(1))) begin
                    state_d = DONE;
                end
            end
            default: begin
                if (valid_i) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            relu_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wren_q  <= 1'b0;
            wrptr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            relu_q  <= relu_d;
            err_q   <= err_d;
            busy_q  <= (state_d == RUN) || (state_d == DRAIN);
            done_q  <= (state_q == DONE);
            wren_q  <= fifo_pop || bypass;
            if (fifo_pop) begin
                wrptr_q <= fifo_head.addr;
                wdata_q <= fifo_head.data;
            end else if (bypass) begin
                wrptr_q <= beat.addr;
                wdata_q <= beat.data;
            end
        end
    end

    assign ifmap_wren_o  = wren_q;
    assign ifmap_wrptr_o = wrptr_q;
    assign ifmap_wdata_o = wdata_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule
